uart_fifo: RTL

Parametrised next-generation UART for the SoC IO bus. It adds configurable character width, optional parity, and TX/RX FIFOs with level reporting. It also adds sticky overrun, framing and parity error flags. The block sits behind the memory-mapped IO decoder; software pushes and pops characters through strobes instead of single-entry buffers.

---
 rtl/uart_fifo.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: UART with programmable baud period, optional parity, and
// show-ahead TX/RX FIFOs with occupancy reporting and sticky RX error flags.
module uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int BAUD_RESET = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_we,
    input  logic [31:0]                   set_baud,
    output logic [31:0]                   get_baud,
    input  logic                          tx_push,
    input  logic [31:0]                   tx_wdata,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_busy,
    input  logic                          rx_pop,
    output logic [31:0]                   rx_rdata,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_overrun,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    input  logic                          err_clr,
    input  logic                          RX,
    output logic                          TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       ODD      = 1'(PARITY_ODD);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    // Upper write-data bits beyond the character width carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^tx_wdata[31:DATA_BITS];

    // ---------------- baud register ----------------
    logic [31:0] baud_q, baud_d;

    // Programmed period, clamped so half-bit timing is never zero.
    always_comb begin
        baud_d = baud_q;
        if (baud_we) baud_d = (set_baud < 32'd2) ? 32'd2 : set_baud;
    end

    // ---------------- TX FIFO + engine ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [LW-1:0]        tx_cnt_q, tx_cnt_d;
    logic                 tx_push_ok, tx_load;
    logic [DATA_BITS-1:0] tx_head;

    state_t               tx_st_q, tx_st_d;
    logic [31:0]          tx_tick_q, tx_tick_d, tx_per_q, tx_per_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d, tx_line_q, tx_line_d, tx_bit_end;

    assign tx_full    = (tx_cnt_q == LW'(FIFO_DEPTH));
    assign tx_push_ok = tx_push && !tx_full;
    assign tx_head    = tx_mem[tx_rp_q];
    assign tx_bit_end = (tx_tick_q == tx_per_q - 32'd1);

    // TX bit sequencer; tx_load pops the FIFO head into the shifter at frame start.
    always_comb begin
        tx_st_d   = tx_st_q;
        tx_tick_d = tx_bit_end ? 32'd0 : tx_tick_q + 32'd1;
        tx_per_d  = tx_per_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_par_d  = tx_par_q;
        tx_line_d = tx_line_q;
        tx_load   = 1'b0;
        case (tx_st_q)
            S_IDLE: begin
                tx_tick_d = 32'd0;
                if (tx_cnt_q != '0) tx_load = 1'b1;
            end
            S_START: if (tx_bit_end) begin
                tx_line_d = tx_sh_q[0];
                tx_sh_d   = tx_sh_q >> 1;
                tx_bit_d  = 3'd0;
                tx_st_d   = S_DATA;
            end
            S_DATA: if (tx_bit_end) begin
                if (tx_bit_q == LAST_BIT) begin
                    if (PARITY_EN != 0) begin
                        tx_line_d = tx_par_q;
                        tx_st_d   = S_PARITY;
                    end else begin
                        tx_line_d = 1'b1;
                        tx_st_d   = S_STOP;
                    end
                end else begin
                    tx_line_d = tx_sh_q[0];
                    tx_sh_d   = tx_sh_q >> 1;
                    tx_bit_d  = tx_bit_q + 3'd1;
                end
            end
            S_PARITY: if (tx_bit_end) begin
                tx_line_d = 1'b1;
                tx_st_d   = S_STOP;
            end
            S_STOP: if (tx_bit_end) begin
                // Chain straight into the next start bit when more data waits.
                if (tx_cnt_q != '0) tx_load = 1'b1;
                else                tx_st_d = S_IDLE;
            end
            default: tx_st_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_st_d   = S_START;
            tx_tick_d = 32'd0;
            tx_per_d  = baud_q;
            tx_sh_d   = tx_head;
            tx_par_d  = ^tx_head ^ ODD;
            tx_line_d = 1'b0;
        end
    end

    // TX FIFO pointer and occupancy update.
    always_comb begin
        tx_wp_d  = tx_wp_q + AW'(tx_push_ok);
        tx_rp_d  = tx_rp_q + AW'(tx_load);
        tx_cnt_d = tx_cnt_q + LW'(tx_push_ok) - LW'(tx_load);
    end

    // TX FIFO storage write.
    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp_q] <= tx_wdata[DATA_BITS-1:0];
    end

    // ---------------- RX synchroniser + engine ----------------
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    state_t               rx_st_q, rx_st_d;
    logic [31:0]          rx_tick_q, rx_tick_d, rx_per_q, rx_per_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_bit_end, rx_half_end;
    logic                 eng_push, frame_evt, par_evt, ovr_evt;

    assign rx_bit_end  = (rx_tick_q == rx_per_q - 32'd1);
    assign rx_half_end = (rx_tick_q == (rx_per_q >> 1) - 32'd1);

    // RX sampler: start bit checked at mid-bit, later bits one period apart.
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_tick_d = rx_tick_q + 32'd1;
        rx_per_d  = rx_per_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_perr_d = rx_perr_q;
        eng_push  = 1'b0;
        frame_evt = 1'b0;
        par_evt   = 1'b0;
        case (rx_st_q)
            S_IDLE: begin
                rx_tick_d = 32'd0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_d   = S_START;
                    rx_per_d  = baud_q;
                    rx_perr_d = 1'b0;
                end
            end
            S_START: if (rx_half_end) begin
                rx_tick_d = 32'd0;
                rx_bit_d  = 3'd0;
                rx_st_d   = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_bit_end) begin
                rx_tick_d = 32'd0;
                rx_sh_d   = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                if (rx_bit_q == LAST_BIT) rx_st_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                else                      rx_bit_d = rx_bit_q + 3'd1;
            end
            S_PARITY: if (rx_bit_end) begin
                rx_tick_d = 32'd0;
                rx_perr_d = ((^rx_sh_q) ^ rx_s2_q) != ODD;
                rx_st_d   = S_STOP;
            end
            S_STOP: if (rx_bit_end) begin
                rx_tick_d = 32'd0;
                if (rx_s2_q) begin
                    eng_push = 1'b1;
                    par_evt  = rx_perr_q;
                    rx_st_d  = S_IDLE;
                end else begin
                    frame_evt = 1'b1;
                    rx_st_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                rx_tick_d = 32'd0;
                if (rx_s2_q) rx_st_d = S_IDLE;
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO + flags ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [LW-1:0]        rx_cnt_q, rx_cnt_d;
    logic                 rx_pop_ok, rx_push_ok, rx_full;
    logic                 ovr_q, ovr_d, ferr_q, ferr_d, perr_flag_q, perr_flag_d;

    assign rx_full    = (rx_cnt_q == LW'(FIFO_DEPTH));
    assign rx_pop_ok  = rx_pop && (rx_cnt_q != '0);
    // A pop in the same cycle frees the slot the incoming character needs.
    assign rx_push_ok = eng_push && (!rx_full || rx_pop_ok);
    assign ovr_evt    = eng_push && rx_full && !rx_pop_ok;

    // RX FIFO pointers and sticky flags; a same-cycle event beats err_clr.
    always_comb begin
        rx_wp_d     = rx_wp_q + AW'(rx_push_ok);
        rx_rp_d     = rx_rp_q + AW'(rx_pop_ok);
        rx_cnt_d    = rx_cnt_q + LW'(rx_push_ok) - LW'(rx_pop_ok);
        ovr_d       = (ovr_q & ~err_clr) | ovr_evt;
        ferr_d      = (ferr_q & ~err_clr) | frame_evt;
        perr_flag_d = (perr_flag_q & ~err_clr) | par_evt;
    end

    // RX FIFO storage write.
    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    // Datapath registers that need no reset.
    always_ff @(posedge clk) begin
        tx_per_q <= tx_per_d;
        tx_sh_q  <= tx_sh_d;
        tx_par_q <= tx_par_d;
        rx_per_q <= rx_per_d;
        rx_sh_q  <= rx_sh_d;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q      <= 32'(BAUD_RESET);
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            tx_st_q     <= S_IDLE;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_line_q   <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_st_q     <= S_IDLE;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_perr_q   <= 1'b0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
            perr_flag_q <= 1'b0;
        end else begin
            baud_q      <= baud_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_st_q     <= tx_st_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_line_q   <= tx_line_d;
            rx_s1_q     <= RX;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_st_q     <= rx_st_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_perr_q   <= rx_perr_d;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
            perr_flag_q <= perr_flag_d;
        end
    end

    assign get_baud      = baud_q;
    assign tx_level      = tx_cnt_q;
    assign tx_busy       = (tx_st_q != S_IDLE);
    assign TX            = tx_line_q;
    assign rx_level      = rx_cnt_q;
    assign rx_empty      = (rx_cnt_q == '0);
    assign rx_rdata      = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp_q]);
    assign rx_overrun    = ovr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = perr_flag_q;

endmodule
